// File: rtl/gradient_pkg.sv
// Shared definitions for the gradient RX path: default stream geometry and the
// framer state encoding.
package gradient_pkg;

  localparam int DATA_W_DEF   = 512;
  localparam int ELEM_W_DEF   = 32;
  localparam int HDR_W_DEF    = 32;
  localparam int EPB_DEF      = DATA_W_DEF / ELEM_W_DEF;
  localparam int LOG2_EPB_DEF = $clog2(EPB_DEF);

  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_BODY = 1'b1
  } frm_state_t;

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXI-Stream output register; upstream ready depends only on the
// register occupancy and downstream ready, so there is no valid->ready path.
module axis_out_reg
  import gradient_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid,
  input  logic         ready,
  output logic         in_ready
);

  assign in_ready = !valid || ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/batch_stream_framer.sv
// Parses the element count from the first beat of each batch, forwards the
// batch beats with a one-cycle register and marks the final beat.
//
// state   | meaning
// ST_HDR  | next accepted beat is a header carrying N
// ST_BODY | forwarding body beats, beats_left counts what remains
module batch_stream_framer
  import gradient_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ELEM_W    = ELEM_W_DEF,
  parameter int HDR_W     = HDR_W_DEF,
  parameter int STRIP_HDR = 1,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          s_tdata,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  output logic [DATA_W-1:0]          m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic [DATA_W/ELEM_W-1:0]   m_elem_vld,
  output logic [HDR_W-1:0]           n_out,
  output logic                       in_batch,
  output logic [CNT_W-1:0]           batch_cnt
);

  localparam int EPB      = DATA_W / ELEM_W;
  localparam int LOG2_EPB = $clog2(EPB);
  localparam int OUT_W    = DATA_W + EPB + 1;
  localparam logic [HDR_W:0] EPB_WIDE = (HDR_W+1)'(EPB);
  localparam logic [HDR_W:0] ONE_BEAT = (HDR_W+1)'(1);

  frm_state_t            state, state_nxt;
  logic [HDR_W:0]        beats_left, beats_left_nxt;
  logic [LOG2_EPB-1:0]   rem_q, rem_nxt;
  logic [HDR_W-1:0]      n_nxt;
  logic                  in_batch_nxt;
  logic                  accept;
  logic [HDR_W-1:0]      hdr_n;
  logic [HDR_W:0]        hdr_beats;
  logic [LOG2_EPB-1:0]   hdr_rem;
  logic [DATA_W-1:0]     data_fwd;
  logic                  last_fwd;
  logic [EPB-1:0]        mask_fwd;
  logic [OUT_W-1:0]      out_q;

  function automatic logic [EPB-1:0] tail_mask(input logic [LOG2_EPB-1:0] r);
    tail_mask = '1;
    if (r != '0) tail_mask = (EPB'(1) << r) - EPB'(1);
  endfunction

  assign accept = s_tvalid && s_tready;
  assign hdr_n  = s_tdata[DATA_W-1 -: HDR_W];
  // One extra bit keeps N = all ones from wrapping when EPB is added.
  assign hdr_beats = ({1'b0, hdr_n} + EPB_WIDE) >> LOG2_EPB;
  assign hdr_rem   = hdr_n[LOG2_EPB-1:0] + LOG2_EPB'(1);

  always_comb begin
    state_nxt      = state;
    beats_left_nxt = beats_left;
    rem_nxt        = rem_q;
    n_nxt          = n_out;
    in_batch_nxt   = in_batch;
    data_fwd       = s_tdata;
    last_fwd       = 1'b0;
    mask_fwd       = '1;
    case (state)
      ST_HDR: begin
        if (STRIP_HDR != 0) data_fwd[DATA_W-1 -: HDR_W] = '0;
        if (accept) begin
          n_nxt   = hdr_n;
          rem_nxt = hdr_rem;
          if (hdr_beats == ONE_BEAT) begin
            last_fwd = 1'b1;
            mask_fwd = tail_mask(hdr_rem);
          end else begin
            beats_left_nxt = hdr_beats - ONE_BEAT;
            in_batch_nxt   = 1'b1;
            state_nxt      = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (accept) begin
          beats_left_nxt = beats_left - ONE_BEAT;
          if (beats_left == ONE_BEAT) begin
            last_fwd     = 1'b1;
            mask_fwd     = tail_mask(rem_q);
            in_batch_nxt = 1'b0;
            state_nxt    = ST_HDR;
          end
        end
      end
      default: state_nxt = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_HDR;
      beats_left <= '0;
      rem_q      <= '0;
      n_out      <= '0;
      in_batch   <= 1'b0;
    end else begin
      state      <= state_nxt;
      beats_left <= beats_left_nxt;
      rem_q      <= rem_nxt;
      n_out      <= n_nxt;
      in_batch   <= in_batch_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      batch_cnt <= '0;
    end else if (m_tvalid && m_tready && m_tlast) begin
      batch_cnt <= batch_cnt + CNT_W'(1);
    end
  end

  axis_out_reg #(.W(OUT_W)) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .d        ({last_fwd, mask_fwd, data_fwd}),
    .q        (out_q),
    .valid    (m_tvalid),
    .ready    (m_tready),
    .in_ready (s_tready)
  );

  assign m_tlast    = out_q[OUT_W-1];
  assign m_elem_vld = out_q[OUT_W-2 -: EPB];
  assign m_tdata    = out_q[DATA_W-1:0];

endmodule

// File: tb/tb_batch_stream_framer.sv
// Bench for batch_stream_framer: element-count reference model, vector table,
// directed corner sequences and a STRIP_HDR=0 / CNT_W=2 instance.
module tb_batch_stream_framer;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic [511:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic [15:0]  m_elem_vld;
  logic [31:0]  n_out;
  logic         in_batch;
  logic [15:0]  batch_cnt;

  logic [511:0] s1_tdata;
  logic         s1_tvalid;
  logic         s1_tready;
  logic [511:0] m1_tdata;
  logic         m1_tvalid;
  logic         m1_tready;
  logic         m1_tlast;
  logic [15:0]  m1_elem_vld;
  logic [31:0]  m1_n_out;
  logic         m1_in_batch;
  logic [1:0]   m1_batch_cnt;

  batch_stream_framer dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_elem_vld(m_elem_vld), .n_out(n_out), .in_batch(in_batch), .batch_cnt(batch_cnt)
  );

  batch_stream_framer #(.STRIP_HDR(0), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .s_tdata(s1_tdata), .s_tvalid(s1_tvalid), .s_tready(s1_tready),
    .m_tdata(m1_tdata), .m_tvalid(m1_tvalid), .m_tready(m1_tready), .m_tlast(m1_tlast),
    .m_elem_vld(m1_elem_vld), .n_out(m1_n_out), .in_batch(m1_in_batch), .batch_cnt(m1_batch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic         last;
    logic [15:0]  mask;
  } beat_t;

  typedef struct {
    logic [31:0] n;
    int          beats;
    logic [15:0] last_mask;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  bit          started = 1'b0;
  int          rdy_mode = 0;
  int          out_beats = 0;
  int          ib_cycles = 0;
  int          stall_seen = 0;
  logic [15:0] last_mask_seen = '0;

  beat_t       exp_q[$];
  bit          md_in_frame = 1'b0;
  longint      md_left = 0;
  logic [31:0] md_n = '0;
  logic [15:0] md_cnt = '0;
  beat_t       md_b;
  int          md_k;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = !m_tready;
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Reference model: tracks elements still owed to the current batch.
  always @(negedge clk) begin
    if (started) begin
      if (!rst) begin
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_elem_vld", m_elem_vld, 0);
        chk("rst_n_out", n_out, 0);
        chk("rst_in_batch", in_batch, 0);
        chk("rst_batch_cnt", batch_cnt, 0);
        exp_q.delete();
        md_in_frame = 1'b0;
        md_left = 0;
        md_n = '0;
        md_cnt = '0;
      end else begin
        chk("m_tvalid", m_tvalid, exp_q.size() != 0);
        if (m_tvalid && exp_q.size() != 0) begin
          chk("m_tdata", m_tdata, exp_q[0].data);
          chk("m_tlast", m_tlast, exp_q[0].last);
          chk("m_elem_vld", m_elem_vld, exp_q[0].mask);
        end
        chk("n_out", n_out, md_n);
        chk("in_batch", in_batch, md_in_frame);
        chk("batch_cnt", batch_cnt, md_cnt);
        chk("s_tready", s_tready, !m_tvalid || m_tready);
        if (in_batch) ib_cycles++;
        if (m_tvalid && !m_tready) stall_seen++;
        if (m_tvalid && m_tready && exp_q.size() != 0) begin
          out_beats++;
          if (exp_q[0].last) begin
            md_cnt = md_cnt + 16'd1;
            last_mask_seen = m_elem_vld;
          end
          void'(exp_q.pop_front());
        end
        if (s_tvalid && s_tready) begin
          md_b.data = s_tdata;
          if (!md_in_frame) begin
            md_n = s_tdata[511:480];
            md_b.data[511:480] = '0;
            md_left = longint'(md_n) + 1;
          end
          md_k = (md_left >= 16) ? 16 : int'(md_left);
          md_left = md_left - md_k;
          md_b.last = (md_left == 0);
          md_b.mask = (md_k == 16) ? 16'hFFFF : 16'((32'd1 << md_k) - 32'd1);
          md_in_frame = !md_b.last;
          exp_q.push_back(md_b);
        end
      end
    end
  end

  task automatic send_beat(input logic [511:0] d);
    int g;
    g = 0;
    s_tdata = d;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && g < 200) begin
      g++;
      @(negedge clk);
    end
    if (!s_tready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=stalled required=accepted");
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] n, input int max_idle);
    longint nb;
    logic [511:0] d;
    nb = (longint'(n) + 1 + 15) / 16;
    for (longint b = 0; b < nb; b++) begin
      if (max_idle > 0) repeat ($urandom_range(0, max_idle)) begin
        @(posedge clk);
        #1;
      end
      d = rand512();
      if (b == 0) d[511:480] = n;
      send_beat(d);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic dut1_frame(input logic [31:0] n, input logic [15:0] emask, input logic [1:0] ecnt);
    logic [511:0] d;
    d = rand512();
    d[511:480] = n;
    s1_tdata = d;
    s1_tvalid = 1'b1;
    @(negedge clk);
    chk("d1_s_tready", s1_tready, 1);
    @(posedge clk);
    #1;
    s1_tvalid = 1'b0;
    @(negedge clk);
    chk("d1_m_tvalid", m1_tvalid, 1);
    chk("d1_m_tdata_intact", m1_tdata, d);
    chk("d1_m_tlast", m1_tlast, 1);
    chk("d1_m_elem_vld", m1_elem_vld, emask);
    chk("d1_n_out", m1_n_out, n);
    chk("d1_in_batch", m1_in_batch, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("d1_batch_cnt", m1_batch_cnt, ecnt);
    chk("d1_m_tvalid_clr", m1_tvalid, 0);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'd15,  1,  16'hFFFF};
    vecs[1] = '{32'd20,  2,  16'h001F};
    vecs[2] = '{32'd47,  3,  16'hFFFF};
    vecs[3] = '{32'd0,   1,  16'h0001};
    vecs[4] = '{32'd31,  2,  16'hFFFF};
    vecs[5] = '{32'd16,  2,  16'h0001};
    vecs[6] = '{32'd100, 7,  16'h001F};
    vecs[7] = '{32'd255, 16, 16'hFFFF};

    rst = 1'b1;
    s_tdata = '0;
    s_tvalid = 1'b0;
    s1_tdata = '0;
    s1_tvalid = 1'b0;
    m_tready = 1'b1;
    m1_tready = 1'b1;
    #2;
    rst = 1'b0;
    started = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      out_beats = 0;
      last_mask_seen = '0;
      send_frame(vecs[i].n, 0);
      drain();
      chk($sformatf("vec%0d_beats", i), out_beats, vecs[i].beats);
      chk($sformatf("vec%0d_last_mask", i), last_mask_seen, vecs[i].last_mask);
    end
    chk("vec_batch_cnt", batch_cnt, 8);

    ib_cycles = 0;
    send_frame(32'd20, 0);
    drain();
    chk("n20_in_batch_cycles", ib_cycles, 1);
    chk("n20_n_out", n_out, 20);

    rdy_mode = 1;
    out_beats = 0;
    stall_seen = 0;
    send_frame(32'd47, 0);
    drain();
    chk("n47_toggle_beats", out_beats, 3);
    chk("n47_stall_seen", stall_seen > 0, 1);
    rdy_mode = 0;
    @(posedge clk);
    #1;

    out_beats = 0;
    send_frame(32'd0, 0);
    send_frame(32'd31, 0);
    drain();
    chk("b2b_beats", out_beats, 3);
    chk("b2b_n_out", n_out, 31);
    chk("b2b_last_mask", last_mask_seen, 16'hFFFF);

    begin
      logic [511:0] d;
      d = rand512();
      d[511:480] = 32'hFFFF_FFFF;
      send_beat(d);
      for (int i = 0; i < 4; i++) send_beat(rand512());
      repeat (2) @(posedge clk);
      #1;
      chk("big_in_batch", in_batch, 1);
      chk("big_n_out", n_out, 32'hFFFF_FFFF);
      rst = 1'b0;
      @(negedge clk);
      chk("big_rst_in_batch", in_batch, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      out_beats = 0;
      send_frame(32'd15, 0);
      drain();
      chk("post_rst_beats", out_beats, 1);
      chk("post_rst_batch_cnt", batch_cnt, 1);
      chk("post_rst_in_batch", in_batch, 0);
    end

    dut1_frame(32'd3, 16'h000F, 2'd1);
    dut1_frame(32'd0, 16'h0001, 2'd2);
    dut1_frame(32'd0, 16'h0001, 2'd3);
    dut1_frame(32'd0, 16'h0001, 2'd0);

    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      logic [31:0] n;
      n = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom_range(0, 40));
      send_frame(n, 2);
    end
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
